// File: rtl/red_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : red_pkg
//  Description : Shared definitions for the red core front end: next-PC
//                select encoding and the default widths / reset vector
//                used by the fetch sequencer, program ROM and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package red_pkg;

    // Default widths shared with the program ROM and decoder.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    // Default program counter value after reset.
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_VEC = '0;

    // Next-PC source select.
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_SEQ  = 2'd0;
    localparam sel_t SEL_BR   = 2'd1;
    localparam sel_t SEL_CALL = 2'd2;
    localparam sel_t SEL_RET  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : Hardware call/return address stack. One push or one pop
//                per cycle; push when full and pop when empty are dropped.
//                Only the stack pointer is reset; entry contents are
//                don't-care until written.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   sp
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_one   = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w:0]   r_sp;
    logic [c_ptr_w:0]   w_sp_dec;
    logic [c_ptr_w-1:0] w_top_idx;

    assign w_sp_dec  = r_sp - c_one;
    assign w_top_idx = w_sp_dec[c_ptr_w-1:0];

    assign full  = (r_sp == c_depth);
    assign empty = (r_sp == '0);
    assign top   = r_mem[w_top_idx];
    assign sp    = r_sp;

    // Stack pointer: pop takes precedence, over/underflowing requests are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (pop && !empty) begin
            r_sp <= w_sp_dec;
        end else if (push && !full) begin
            r_sp <= r_sp + c_one;
        end
    end

    // Entry storage: the slot just above the current top receives the push.
    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            r_mem[r_sp[c_ptr_w-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq
//  Description : Instruction-fetch sequencer for the red core. Holds the PC,
//                drives an asynchronous-read program ROM, registers the
//                fetched word into the instruction register and handles
//                branch, call and return redirects with an optional
//                architectural branch-delay slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq
    import red_pkg::*;
#(
    parameter int                DATA_W            = DEF_DATA_W,
    parameter int                ADDR_W            = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC         = ADDR_W'(DEF_RESET_VEC),
    parameter int                STACK_DEPTH       = 4,
    parameter int                FLUSH_ON_REDIRECT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              br,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              stk_ovf,
    output logic              stk_unf
);

    localparam int                c_sp_w   = $clog2(STACK_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic              r_stk_ovf;
    logic              r_stk_unf;

    logic              w_adv;
    sel_t              w_sel;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_redirect;
    logic              w_ir_valid_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic [ADDR_W-1:0] w_stk_top;
    logic              w_stk_full;
    logic              w_stk_empty;
    logic [c_sp_w-1:0] w_stk_sp;

    // Reset outranks everything, so a request in a reset cycle never advances.
    assign w_adv    = en & ~stall & ~rst;
    assign w_pc_inc = r_pc + c_pc_one;
    assign rom_addr = r_pc;

    // Next-PC source: ret > call > br > sequential; a ret with nothing
    // on the stack is not a redirect and falls through to sequential.
    always_comb begin
        w_sel = SEL_SEQ;
        if (ret) begin
            if (!w_stk_empty) begin
                w_sel = SEL_RET;
            end
        end else if (call) begin
            w_sel = SEL_CALL;
        end else if (br) begin
            w_sel = SEL_BR;
        end
    end

    // Next-PC mux driven by the resolved source.
    always_comb begin
        w_pc_nxt = w_pc_inc;
        case (w_sel)
            SEL_RET:  w_pc_nxt = w_stk_top;
            SEL_CALL: w_pc_nxt = target;
            SEL_BR:   w_pc_nxt = target;
            default:  w_pc_nxt = w_pc_inc;
        endcase
    end

    assign w_redirect = (w_sel != SEL_SEQ);

    // The return address is pc+1, which in delay-slot mode is the word
    // after the slot instruction fetched alongside the call.
    assign w_push    = w_adv & (w_sel == SEL_CALL) & ~w_stk_full;
    assign w_pop     = w_adv & (w_sel == SEL_RET);
    assign w_ovf_evt = (w_sel == SEL_CALL) & w_stk_full;
    // Underflow keys off the depth count itself rather than the empty flag.
    assign w_unf_evt = ret & (w_stk_sp == '0);

    generate
        if (FLUSH_ON_REDIRECT != 0) begin : g_flush
            // The word fetched alongside a redirect is wrong-path: kill it.
            assign w_ir_valid_nxt = ~w_redirect;
        end else begin : g_delay_slot
            // The word fetched alongside a redirect is the delay slot.
            assign w_ir_valid_nxt = 1'b1;
        end
    endgenerate

    // PC, instruction register and sticky flags; frozen unless advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_stk_ovf  <= 1'b0;
            r_stk_unf  <= 1'b0;
        end else if (w_adv) begin
            r_pc       <= w_pc_nxt;
            r_ir       <= rom_data;
            r_ir_pc    <= r_pc;
            r_ir_valid <= w_ir_valid_nxt;
            r_stk_ovf  <= r_stk_ovf | w_ovf_evt;
            r_stk_unf  <= r_stk_unf | w_unf_evt;
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_stk_top),
        .full      (w_stk_full),
        .empty     (w_stk_empty),
        .sp        (w_stk_sp)
    );

    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign stk_ovf  = r_stk_ovf;
    assign stk_unf  = r_stk_unf;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_seq
//  Description : Scoreboard bench for fetch_seq. Two instances (kill-on-
//                redirect and delay-slot) share one stimulus stream; a
//                behavioural model predicts the post-edge outputs of both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;
    import red_pkg::*;

    localparam logic [7:0] c_rv    = 8'h10;
    localparam int         c_depth = 4;

    logic        clk = 1'b0;
    logic        rst, en, stall, br, call, ret;
    logic [7:0]  target;
    logic [7:0]  rom_addr_f, rom_addr_d, ir_pc_f, ir_pc_d;
    logic [15:0] rom_data_f, rom_data_d, ir_f, ir_d;
    logic        irv_f, irv_d, ovf_f, ovf_d, unf_f, unf_d;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Program ROM contents: ROM[a] = A000 + a.
    assign rom_data_f = 16'hA000 + {8'h00, rom_addr_f};
    assign rom_data_d = 16'hA000 + {8'h00, rom_addr_d};

    fetch_seq #(.DATA_W(16), .ADDR_W(8), .RESET_VEC(c_rv), .STACK_DEPTH(c_depth),
                .FLUSH_ON_REDIRECT(1)) dut_f (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .br(br), .call(call), .ret(ret),
        .target(target), .rom_addr(rom_addr_f), .rom_data(rom_data_f), .ir(ir_f),
        .ir_pc(ir_pc_f), .ir_valid(irv_f), .stk_ovf(ovf_f), .stk_unf(unf_f));

    fetch_seq #(.DATA_W(16), .ADDR_W(8), .RESET_VEC(c_rv), .STACK_DEPTH(c_depth),
                .FLUSH_ON_REDIRECT(0)) dut_d (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .br(br), .call(call), .ret(ret),
        .target(target), .rom_addr(rom_addr_d), .rom_data(rom_data_d), .ir(ir_d),
        .ir_pc(ir_pc_d), .ir_valid(irv_d), .stk_ovf(ovf_d), .stk_unf(unf_d));

    typedef struct {
        logic [7:0]  rom_addr;
        logic [15:0] ir;
        logic [7:0]  ir_pc;
        logic        irv_flush;
        logic        irv_slot;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state: architectural view only.
    int m_pc, m_ir, m_ir_pc;
    int m_stk[$];
    bit m_irv_f, m_irv_d, m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the result of the coming edge, queue it.
    task automatic step(input bit r, input bit e, input bit s, input bit b,
                        input bit c, input bit rt, input logic [7:0] tgt);
        exp_t x;
        int   npc;
        bit   redir;
        rst = r; en = e; stall = s; br = b; call = c; ret = rt; target = tgt;
        if (r) begin
            m_pc = int'(c_rv); m_ir = 0; m_ir_pc = 0;
            m_irv_f = 0; m_irv_d = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (e && !s) begin
            npc   = (m_pc + 1) % 256;
            redir = 0;
            if (rt) begin
                if (m_stk.size() > 0) begin
                    npc   = m_stk.pop_back();
                    redir = 1;
                end else begin
                    m_unf = 1;
                end
            end else if (c) begin
                redir = 1;
                if (m_stk.size() == c_depth) m_ovf = 1;
                else m_stk.push_back((m_pc + 1) % 256);
                npc = int'(tgt);
            end else if (b) begin
                redir = 1;
                npc   = int'(tgt);
            end
            m_ir    = 'hA000 + m_pc;
            m_ir_pc = m_pc;
            m_irv_f = !redir;
            m_irv_d = 1;
            m_pc    = npc;
        end
        x.rom_addr  = 8'(m_pc);
        x.ir        = 16'(m_ir);
        x.ir_pc     = 8'(m_ir_pc);
        x.irv_flush = m_irv_f;
        x.irv_slot  = m_irv_d;
        x.ovf       = m_ovf;
        x.unf       = m_unf;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: after every edge, pop the prediction and compare both instances.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("rom_addr_f", 32'(rom_addr_f), 32'(mon_e.rom_addr));
            check("rom_addr_d", 32'(rom_addr_d), 32'(mon_e.rom_addr));
            check("ir_f",       32'(ir_f),       32'(mon_e.ir));
            check("ir_d",       32'(ir_d),       32'(mon_e.ir));
            check("ir_pc_f",    32'(ir_pc_f),    32'(mon_e.ir_pc));
            check("ir_pc_d",    32'(ir_pc_d),    32'(mon_e.ir_pc));
            check("ir_valid_f", 32'(irv_f),      32'(mon_e.irv_flush));
            check("ir_valid_d", 32'(irv_d),      32'(mon_e.irv_slot));
            check("stk_ovf_f",  32'(ovf_f),      32'(mon_e.ovf));
            check("stk_ovf_d",  32'(ovf_d),      32'(mon_e.ovf));
            check("stk_unf_f",  32'(unf_f),      32'(mon_e.unf));
            check("stk_unf_d",  32'(unf_d),      32'(mon_e.unf));
        end
    end

    initial begin
        // Reset, then sequential run from the reset vector.
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 0, 8'h00);
        adv(4);
        // Wrap at the top of the address space.
        step(0, 1, 0, 1, 0, 0, 8'hFE);
        adv(3);
        // Branch 20 -> 40.
        step(0, 1, 0, 1, 0, 0, 8'h20);
        step(0, 1, 0, 1, 0, 0, 8'h40);
        adv(2);
        // Call 30 -> 50, run to 52, return to 31.
        step(0, 1, 0, 1, 0, 0, 8'h30);
        step(0, 1, 0, 0, 1, 0, 8'h50);
        adv(2);
        step(0, 1, 0, 0, 0, 1, 8'h00);
        adv(1);
        // Nested calls, fifth overflows; five returns, fifth underflows.
        step(0, 1, 0, 0, 1, 0, 8'h60);
        step(0, 1, 0, 0, 1, 0, 8'h70);
        step(0, 1, 0, 0, 1, 0, 8'h80);
        step(0, 1, 0, 0, 1, 0, 8'h90);
        step(0, 1, 0, 0, 1, 0, 8'hA0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 8'h00);
        adv(3);
        // Simultaneous call and ret on an empty stack: ret wins.
        step(0, 1, 0, 0, 1, 1, 8'h44);
        adv(1);
        step(1, 1, 0, 0, 0, 0, 8'h00);
        // Stall with branch held, then taken once stall drops.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 8'hC0);
        step(0, 1, 0, 1, 0, 0, 8'hC0);
        adv(1);
        // Enable low ignores a call.
        step(0, 0, 0, 0, 1, 0, 8'h77);
        adv(1);
        // Reset during a call cycle: no push, no jump.
        step(0, 1, 0, 0, 1, 0, 8'h66);
        step(1, 1, 0, 0, 1, 0, 8'h55);
        adv(2);
        step(0, 1, 0, 0, 0, 1, 8'h00);
        adv(1);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 8'($urandom));
        end
        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
